// File: rtl/div_unit_pkg.sv
// Shared encodings for the execute-stage divider.
// Holds state codes, ready flags and start/stop constants.
// No logic; imported by div_unit and div_step.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract divisor from shifted partial remainder.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] diff;

    // Extra top bit of diff is the borrow; a borrow means the divisor did not fit.
    always_comb begin
        diff = {1'b0, partial_i} - {2'b00, divisor_i};
        if (diff[WIDTH+1]) begin
            rem_o  = partial_i[WIDTH-1:0];
            qbit_o = 1'b0;
        end else begin
            rem_o  = diff[WIDTH-1:0];
            qbit_o = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (signed/unsigned) returning {remainder, quotient}.
// Latency: ready_o WIDTH+1 clocks after start is sampled; 2 for divide-by-zero.
// Backpressure: result held while start_i stays high; optional DIV_EARLY_EXIT_EN shortcut.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 divzero_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               divzero_q, divzero_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   quo_last, quo_fix, rem_fix;

    // Magnitudes of the operands; only signed requests with a set MSB are negated.
    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    // The dividend MSB shifts into the partial remainder each iteration.
    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i ({rem_q, dvd_q[WIDTH-1]}),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Final iteration result with sign fix-up, loaded straight into result on the last step.
    always_comb begin
        quo_last = {dvd_q[WIDTH-2:0], step_qbit};
        quo_fix  = quo_neg_q ? -quo_last : quo_last;
        rem_fix  = rem_neg_q ? -step_rem : step_rem;
    end

    // Next-state and datapath control; ready/divzero rise on the first clock spent in END.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        result_d  = result_q;
        ready_d   = ready_q;
        divzero_d = divzero_q;

        case (state_q)
            DIV_IDLE: begin
                ready_d   = DivResultNotReady;
                divzero_d = 1'b0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        dz_d    = 1'b1;
                        state_d = DIV_BYZERO;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (op2_abs > op1_abs) begin
                        dz_d     = 1'b0;
                        result_d = {opdata1_i, {WIDTH{1'b0}}};
                        state_d  = DIV_END;
                    end
`endif
                    else begin
                        rem_d     = '0;
                        dvd_d     = op1_abs;
                        dsr_d     = op2_abs;
                        quo_neg_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        rem_neg_d = signed_div_i & opdata1_i[WIDTH-1];
                        cnt_d     = '0;
                        dz_d      = 1'b0;
                        state_d   = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    result_d = '0;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = quo_last;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = {rem_fix, quo_fix};
                        state_d  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DivStop) begin
                    ready_d   = DivResultNotReady;
                    divzero_d = 1'b0;
                    state_d   = DIV_IDLE;
                end else begin
                    ready_d   = DivResultReady;
                    divzero_d = dz_q;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        busy_d = (state_d != DIV_IDLE);
    end

    // State and output registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
            divzero_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            divzero_q <= divzero_d;
            busy_q    <= busy_d;
        end
    end

    assign result_o  = result_q;
    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign divzero_o = divzero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (WIDTH=32): latency, signed/unsigned results,
// divide-by-zero, annul, mid-operation reset, result hold and early exit.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        divzero_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .divzero_o    (divzero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise start and count clocks (edge 0 samples start) until ready_o; bounded.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output int lat, output logic [63:0] res, output logic dz);
        bit done;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        lat  = -1;
        res  = '0;
        dz   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                lat  = i;
                res  = result_o;
                dz   = divzero_o;
                done = 1'b1;
            end
        end
    endtask

    task automatic drop_start();
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", result_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_cmp++; if (divzero_o !== 1'b0) begin n_bad++; $display("FAIL reset_divzero got %b want 0", divzero_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat; logic [63:0] res; logic dz;
        run_div(32'd100, 32'd7, 1'b0, lat, res, dz);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL u100_7_latency got %0d want 33", lat); end
        n_cmp++; if (res !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL u100_7_result got %h want %h", res, {32'd2, 32'd14}); end
        n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL u100_7_divzero got %b want 0", dz); end
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL u100_7_busy_end got %b want 1", busy_o); end
        drop_start();
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL u100_7_ready_drop got %b want 0", ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL u100_7_busy_drop got %b want 0", busy_o); end
        n_cmp++; if (result_o !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL u100_7_retained got %h want %h", result_o, {32'd2, 32'd14}); end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res; logic dz;
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res, dz);
        n_cmp++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_bad++; $display("FAIL s_m7_2_result got %h want ffffffff_fffffffd", res); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL s_m7_2_latency got %0d want 33", lat); end
        drop_start();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res, dz);
        n_cmp++; if (res !== {32'h0, 32'h8000_0000}) begin n_bad++; $display("FAIL s_min_m1_result got %h want 00000000_80000000", res); end
        n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL s_min_m1_divzero got %b want 0", dz); end
        drop_start();
        // Same bit pattern unsigned: 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res, dz);
        n_cmp++; if (res !== {32'h8000_0000, 32'h0}) begin n_bad++; $display("FAIL u_big_result got %h want 80000000_00000000", res); end
        drop_start();
    endtask

    task automatic test_divzero();
        int lat; logic [63:0] res; logic dz;
        run_div(32'd5, 32'd0, 1'b0, lat, res, dz);
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL dz_latency got %0d want 2", lat); end
        n_cmp++; if (res !== 64'd0) begin n_bad++; $display("FAIL dz_result got %h want 0", res); end
        n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", dz); end
        drop_start();
        n_cmp++; if (divzero_o !== 1'b0) begin n_bad++; $display("FAIL dz_flag_drop got %b want 0", divzero_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL dz_ready_drop got %b want 0", ready_o); end
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res; logic dz; int seen;
        opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd1; signed_div_i = 1'b0; start_i = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL annul_busy got %b want 0", busy_o); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL annul_ready_cycles got %0d want 0", seen); end
        run_div(32'd9, 32'd3, 1'b0, lat, res, dz);
        n_cmp++; if (res !== {32'd0, 32'd3}) begin n_bad++; $display("FAIL after_annul_result got %h want %h", res, {32'd0, 32'd3}); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL after_annul_latency got %0d want 33", lat); end
        drop_start();
    endtask

    task automatic test_reset_mid();
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (result_o !== 64'd0) begin n_bad++; $display("FAIL midrst_result got %h want 0", result_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b want 0", ready_o); end
        n_cmp++; if (divzero_o !== 1'b0) begin n_bad++; $display("FAIL midrst_divzero got %b want 0", divzero_o); end
        rst = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int lat; logic [63:0] res; logic dz;
        run_div(32'd100, 32'd7, 1'b0, lat, res, dz);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (result_o !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL hold_result_%0d got %h want %h", k, result_o, {32'd2, 32'd14}); end
            n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL hold_ready_%0d got %b want 1", k, ready_o); end
        end
        drop_start();
    endtask

    task automatic test_early();
        int lat; logic [63:0] res; logic dz; int exp_lat;
`ifdef DIV_EARLY_EXIT_EN
        exp_lat = 1;
`else
        exp_lat = 33;
`endif
        run_div(32'd5, 32'd9, 1'b0, lat, res, dz);
        n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL early_latency got %0d want %0d", lat, exp_lat); end
        n_cmp++; if (res !== {32'd5, 32'd0}) begin n_bad++; $display("FAIL early_result got %h want %h", res, {32'd5, 32'd0}); end
        drop_start();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_reset_mid();
        test_hold();
        test_early();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle restoring divider for the 5-stage pipeline; the execute stage instantiates it for DIV/DIVU.
- Supports signed and unsigned operands of configurable width and returns {remainder, quotient} for the HI/LO write.
- Exposes busy/ready so that ex raises a stall request to ctrl while a division is in flight.
- Accepts an annul for flush of the issuing instruction.

Parameters:
- WIDTH, 32, operand width in bits (>=4). Iteration counter width CNT_W = $clog2(WIDTH)+1 is a derived localparam.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  request; held high by ex until ready_o is seen
- annul_i  input  1  abort the current division (pipeline flush)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  input  WIDTH  dividend; sampled with start_i
- opdata2_i  input  WIDTH  divisor; sampled with start_i
- result_o  output  2*WIDTH  {remainder, quotient}; valid while ready_o=1
- ready_o  output  1  result valid
- busy_o  output  1  high in ON/BYZERO/END; ex ORs it into stallreq
- divzero_o  output  1  high with ready_o when the divisor was zero

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; result_o=0, ready_o=0, busy_o=0, divzero_o=0. Reset overrides every other input, including mid-operation.
- States: IDLE, BYZERO, ON, END. All outputs are registered.
- IDLE, start_i=1, annul_i=0:
  - divisor==0 -> BYZERO.
  - Otherwise latch |op1| and |op2| (two's-complement negation only when signed_div_i=1 and MSB=1), latch the sign flags, clear counter -> ON.
- IDLE, start_i=0 or annul_i=1: stay in IDLE.
- BYZERO: next edge -> END with result_o=0 and divzero_o=1.
- ON: one restoring step per clock.
  - Shift the {partial remainder, dividend} register left by 1, then trial-subtract the divisor from the upper WIDTH+1 bits.
  - Non-negative difference: keep it and set quotient bit 1; negative: quotient bit 0.
  - Counter increments each step; after exactly WIDTH steps -> END.
- END entry:
  - Apply sign fix-up: quotient negated if the signs differed; remainder negated if the dividend was negative (signed only).
  - Load result_o and set ready_o=1.
- END: hold result_o/ready_o until start_i=0, then -> IDLE, ready_o=0, divzero_o=0, result_o retained.
- Latency: ready_o is high exactly WIDTH+1 clocks after the edge that sampled start_i (divide-by-zero: 2 clocks).
- annul_i=1 in ON or BYZERO: next state IDLE, ready_o stays 0, no result. annul_i in END: -> IDLE, ready_o=0.
- Back-to-back: a new start is accepted only from IDLE, so at least one clock with start_i=0 separates operations.
- Overflow (signed MIN/-1): quotient wraps to MIN, remainder 0; no flag.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE, if |divisor| > |dividend| (divisor nonzero), go directly to END with quotient=0, remainder=dividend (original signed value).
  - ready_o rises 1 clock after start.
- Undefined: the full WIDTH-step latency applies to every nonzero divisor.

Decomposition:
- Shared package/define file (same as other pipeline macros):
  - state encodings DIV_IDLE/DIV_BYZERO/DIV_ON/DIV_END;
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop constants.
- Natural sub-module: div_step — combinational one-iteration shift/trial-subtract slice (inputs: partial remainder, divisor; outputs: next remainder, quotient bit). Reused if radix-4 is added later.

Test Plan:
- Unsigned 100 / 7, WIDTH=32 -> ready_o exactly 33 clocks after start, result_o = {32'd2, 32'd14}, divzero_o=0.
- Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divisor 0 (any dividend) -> ready_o after 2 clocks, result_o=0, divzero_o=1; drop start_i -> IDLE next clock, divzero_o=0.
- Unsigned 0xFFFFFFFF / 1, annul_i pulsed at step 10 -> IDLE next clock, ready_o never asserts; a fresh 9/3 afterwards -> {0, 3}.
- rst asserted mid-ON -> all outputs 0 next clock, busy_o=0; start_i held high while in END -> result held stable for 5 clocks.
- With DIV_EARLY_EXIT_EN: 5 / 9 -> ready_o 1 clock after start, result {5, 0}; without the macro -> 33 clocks, same result.
